z_csa_pipe: RTL



---
 rtl/z_csa_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/z_csa_pipe.sv
// z_csa_pipe: pipelined carry-select adder/subtractor.
// One BLOCK-bit slice per stage, global-stall valid/ready flow control.
module z_csa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTG = WIDTH / BLOCK;

    logic             adv;
    logic             acc;
    logic [WIDTH-1:0] b_e;
    logic             ci_e;

    // BLOCK-bit ripple chain; returns {carry_out, sum}
    function automatic logic [BLOCK:0] ripple(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             ci
    );
        logic [BLOCK:0]   c;
        logic [BLOCK-1:0] s;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[BLOCK], s};
    endfunction

    // The whole pipe advances together; stall only when the output is held
    assign adv  = !out_valid || out_ready;
    assign in_ready = adv;
    assign acc  = in_valid && adv;
    assign b_e  = sub ? ~b : b;
    assign ci_e = sub | c_in;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = (k + 1) * BLOCK;
        localparam int HI = WIDTH - LO;

        logic [BLOCK-1:0] x;
        logic [BLOCK-1:0] y;
        logic             ci;
        logic             pv;
        logic [BLOCK:0]   r0;
        logic [BLOCK:0]   r1;
        logic [BLOCK:0]   rs;
        logic [LO-1:0]    s_d;
        logic             v_q;
        logic             c_q;
        logic [LO-1:0]    s_q;

        if (k == 0) begin : g_in
            assign x   = a[BLOCK-1:0];
            assign y   = b_e[BLOCK-1:0];
            assign ci  = ci_e;
            assign pv  = acc;
            assign s_d = rs[BLOCK-1:0];
        end else begin : g_in
            assign x   = g_stg[k-1].g_up.a_q[BLOCK-1:0];
            assign y   = g_stg[k-1].g_up.b_q[BLOCK-1:0];
            assign ci  = g_stg[k-1].c_q;
            assign pv  = g_stg[k-1].v_q;
            assign s_d = {rs[BLOCK-1:0], g_stg[k-1].s_q};
        end

        // Both carry hypotheses; the registered carry picks one
        assign r0 = ripple(x, y, 1'b0);
        assign r1 = ripple(x, y, 1'b1);
        assign rs = ci ? r1 : r0;

        // Valid bit shifts on every advance, bubbles included
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= pv;
            end
        end

        // Data only loads for real operations so outputs hold over bubbles
        always_ff @(posedge clk) begin
            if (rst) begin
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv && pv) begin
                c_q <= rs[BLOCK];
                s_q <= s_d;
            end
        end

        if (k < NSTG - 1) begin : g_up
            logic [HI-1:0] a_d;
            logic [HI-1:0] b_d;
            logic [HI-1:0] a_q;
            logic [HI-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = a[WIDTH-1:BLOCK];
                assign b_d = b_e[WIDTH-1:BLOCK];
            end else begin : g_src
                assign a_d = g_stg[k-1].g_up.a_q[HI+BLOCK-1:BLOCK];
                assign b_d = g_stg[k-1].g_up.b_q[HI+BLOCK-1:BLOCK];
            end

            // Carry the not-yet-added operand bits down the pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && pv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSTG - 1) begin : g_last
            logic cm;
            logic o_q;

            // Carry into the MSB recovered from the MSB sum bit
            assign cm = x[BLOCK-1] ^ y[BLOCK-1] ^ rs[BLOCK-1];

            // Overflow flag registered alongside the final sum
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q <= 1'b0;
                end else if (adv && pv) begin
                    o_q <= rs[BLOCK] ^ cm;
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_q;
    assign sum       = g_stg[NSTG-1].s_q;
    assign c_out     = g_stg[NSTG-1].c_q;
    assign ovf       = g_stg[NSTG-1].g_last.o_q;

endmodule
